// File: rtl/rf_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rf_ctrl_pkg
// Shared definitions for the register-file writeback control slice.
//   - Default widths and depths for data, register index and scoreboard.
//   - wb_src_t: which requester owns the write port in a given cycle.
//   - wait_cnt_width(): width of the ALU starvation counter for a given limit.
// ----------------------------------------------------------------------------
package rf_ctrl_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_ADDR_DEPTH = 32;
    localparam int RF_MAX_WAIT   = 3;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LSU  = 2'd2
    } wb_src_t;

    // Enough bits to hold 0..max_wait; never narrower than one bit.
    function automatic int wait_cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ----------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per architectural register, marking destinations with an
// outstanding write.
//   clk, rst_n      : clock, asynchronous active-low reset (clears all bits)
//   set_en, set_rd  : mark set_rd busy at the next edge (ignored for reg 0)
//   clr_en, clr_rd  : mark clr_rd free at the next edge
//   q_rs1, q_rs2    : combinational source-register queries
//   rs1_busy/rs2_busy: busy bit of the queried registers
//   busy            : full busy vector (bit 0 is always 0)
// A set and a clear of the same register at the same edge leaves it busy:
// the newly issued instruction still owes a write.
// ----------------------------------------------------------------------------
module rf_scoreboard
    import rf_ctrl_pkg::*;
#(
    parameter int ADDR_DEPTH = RF_ADDR_DEPTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_rd,
    input  logic [ADDR_WIDTH-1:0] q_rs1,
    input  logic [ADDR_WIDTH-1:0] q_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [ADDR_DEPTH-1:0] busy
);

    logic [ADDR_DEPTH-1:0] busy_q;
    logic [ADDR_DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) begin
            busy_nxt[clr_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge set wins.
        if (set_en && (set_rd != '0)) begin
            busy_nxt[set_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy     = busy_q;
    assign rs1_busy = busy_q[q_rs1];
    assign rs2_busy = busy_q[q_rs2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port (we3/a3/wd3) between the ALU
// writeback path and the LSU load-return path, and tracks in-flight
// destinations for decode hazard stalls.
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     : ALU writeback request
//   alu_ready                     : ALU request accepted this cycle
//   lsu_valid/lsu_rd/lsu_data     : LSU writeback request
//   lsu_ready                     : LSU request accepted this cycle
//   iss_valid/iss_rd              : issuing instruction's destination
//   q_rs1, q_rs2                  : decode source queries
//   rs1_busy, rs2_busy            : queried register has an outstanding write
//   sb_busy                       : full scoreboard vector
//   we3, a3, wd3                  : registered register-file write port
//   byp1_hit/byp1_data,
//   byp2_hit/byp2_data            : only with RF_WB_BYPASS_EN defined; the
//                                   write being committed this cycle matches
//                                   the query, so decode may use wd3 directly
//
// Handshake: a request transfers in a cycle where valid && ready are both
// high; the requester holds valid/rd/data stable until then. ready is
// combinational from both valids and the wait counter, and at most one ready
// is high per cycle.
//
// Arbitration: a lone requester wins. On contention the LSU wins unless the
// ALU has already lost MAX_WAIT consecutive cycles, in which case the ALU is
// forced through. A grant in cycle N produces the write in cycle N+1.
// ----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_DEPTH = RF_ADDR_DEPTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int MAX_WAIT   = RF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  lsu_ready,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] q_rs1,
    input  logic [ADDR_WIDTH-1:0] q_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [ADDR_DEPTH-1:0] sb_busy,
`ifdef RF_WB_BYPASS_EN
    output logic                  byp1_hit,
    output logic [DATA_WIDTH-1:0] byp1_data,
    output logic                  byp2_hit,
    output logic [DATA_WIDTH-1:0] byp2_data,
`endif
    output logic                  we3,
    output logic [ADDR_WIDTH-1:0] a3,
    output logic [DATA_WIDTH-1:0] wd3
);

    localparam int WW = wait_cnt_width(MAX_WAIT);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    wb_src_t               grant;
    logic [WW-1:0]         wait_cnt;
    logic [WW-1:0]         wait_cnt_nxt;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sb_rs1_busy;
    logic                  sb_rs2_busy;

    // Grant select, write-port mux and starvation counter update.
    always_comb begin
        grant        = SRC_NONE;
        sel_rd       = '0;
        sel_data     = '0;
        wait_cnt_nxt = '0;

        if (alu_valid && lsu_valid) begin
            grant = (wait_cnt == WAIT_LIMIT) ? SRC_ALU : SRC_LSU;
        end else if (alu_valid) begin
            grant = SRC_ALU;
        end else if (lsu_valid) begin
            grant = SRC_LSU;
        end

        case (grant)
            SRC_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            SRC_LSU: begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase

        // Counts only consecutive losses of a pending ALU request.
        if (alu_valid && (grant != SRC_ALU)) begin
            wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    // Gate with rst_n so nothing is accepted while reset is held.
    assign alu_ready = rst_n && (grant == SRC_ALU);
    assign lsu_ready = rst_n && (grant == SRC_LSU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            // Writes to register 0 are accepted but never reach the port.
            we3      <= (grant != SRC_NONE) && (sel_rd != '0);
            if (grant != SRC_NONE) begin
                a3  <= sel_rd;
                wd3 <= sel_data;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_DEPTH (ADDR_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_rd   (iss_rd),
        .clr_en   (we3),
        .clr_rd   (a3),
        .q_rs1    (q_rs1),
        .q_rs2    (q_rs2),
        .rs1_busy (sb_rs1_busy),
        .rs2_busy (sb_rs2_busy),
        .busy     (sb_busy)
    );

`ifdef RF_WB_BYPASS_EN
    // The committing write forwards straight to decode, so the busy bit
    // (still set until the end of this cycle) is hidden for that query.
    assign byp1_hit  = we3 && (a3 == q_rs1) && (q_rs1 != '0);
    assign byp2_hit  = we3 && (a3 == q_rs2) && (q_rs2 != '0);
    assign byp1_data = wd3;
    assign byp2_data = wd3;
    assign rs1_busy  = sb_rs1_busy && !byp1_hit;
    assign rs2_busy  = sb_rs2_busy && !byp2_hit;
`else
    assign rs1_busy  = sb_rs1_busy;
    assign rs2_busy  = sb_rs2_busy;
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the single register-file write port (WE3/A3/WD3) between two writeback requesters: the ALU result path and the load/store unit (LSU) load-return path.
- Keeps a per-register scoreboard of in-flight destinations so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.
- Drives the register file's write port from registered outputs.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_DEPTH, 32, number of architectural registers (scoreboard bits).
- ADDR_WIDTH, 5, register index width.
- MAX_WAIT, 3, consecutive cycles the ALU may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  load data.
- lsu_ready  out  1  LSU request accepted this cycle.
- iss_valid  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- q_rs1, q_rs2  in  ADDR_WIDTH  decode source-register queries.
- rs1_busy, rs2_busy  out  1  queried register has an outstanding write.
- sb_busy  out  ADDR_DEPTH  full scoreboard vector.
- we3  out  1  register-file write enable.
- a3  out  ADDR_WIDTH  register-file write address.
- wd3  out  DATA_WIDTH  register-file write data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - we3=0, a3=0, wd3=0.
  - sb_busy=0.
  - Wait counter = 0.
  - alu_ready=0 and lsu_ready=0 while rst_n is low.
- Handshake:
  - A transfer occurs when valid && ready are both high in the same cycle.
  - A requester holds valid, rd and data stable until it is accepted.
  - ready is combinational from the valid inputs and the wait counter.
  - At most one grant per cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid and wait_cnt < MAX_WAIT: LSU is granted.
  - Both valid and wait_cnt == MAX_WAIT: ALU is granted.
- Wait counter:
  - Increments (saturating at MAX_WAIT) when alu_valid is high and the ALU is not granted.
  - Clears when the ALU is granted or alu_valid is low.
  - Width is clog2(MAX_WAIT+1).
- Write latency:
  - A grant in cycle N drives we3=1, a3=rd, wd3=data throughout cycle N+1.
  - The register file commits at the end of N+1.
  - we3 is a single-cycle pulse per grant. Back-to-back grants give back-to-back we3 pulses.
  - No grant in cycle N gives we3=0 in N+1. a3 and wd3 hold their last values.
- Register 0:
  - A request with rd==0 is still accepted (ready=1), but we3 stays 0 in N+1. Register 0 is never written.
- Scoreboard:
  - Set: at the clock edge where iss_valid && iss_rd!=0, sb_busy[iss_rd] is set.
  - Clear: at the clock edge ending a cycle with we3 high, sb_busy[a3] is cleared.
  - Same register set and cleared at the same edge: set wins.
  - sb_busy[0] is constant 0.
- Busy queries: rsX_busy = sb_busy[q_rsX], combinational.
- Reset mid-operation: any write pending in the output register is dropped (we3 forced 0), and all scoreboard bits are cleared.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Adds outputs byp1_hit, byp2_hit (1 bit) and byp1_data, byp2_data (DATA_WIDTH).
  - byp1_hit = we3 && a3==q_rs1 && q_rs1!=0, with byp1_data = wd3. The same rule applies for rs2.
  - rsX_busy is masked to 0 when bypX_hit is high, so decode proceeds in the commit cycle.
- Undefined:
  - No bypass ports.
  - rsX_busy stays high through the commit cycle and drops the cycle after.

Decomposition:
- Shared package rf_ctrl_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH and ADDR_DEPTH defaults.
  - Enum wb_src_t {SRC_NONE, SRC_ALU, SRC_LSU}, used for the grant select.
  - Function computing the wait-counter width.
- One natural sub-module, rf_scoreboard: busy vector, set/clear logic and the two query ports.
- Arbitration and the output register stay in the top level.

Test Plan:
- Single request: alu_valid, alu_rd=5, alu_data=0xDEADBEEF in cycle 1 -> alu_ready=1 in cycle 1; we3=1, a3=5, wd3=0xDEADBEEF in cycle 2; we3=0 in cycle 3.
- Contention and aging, MAX_WAIT=3: both valid every cycle with fresh requests -> LSU wins cycles 1-3, ALU wins cycle 4, counter clears, LSU wins cycle 5.
- Register 0: lsu_rd=0 -> lsu_ready=1; we3 stays 0 the next cycle; sb_busy[0] stays 0 even with iss_rd=0.
- Scoreboard: iss_rd=7 in cycle 1 -> sb_busy[7]=1 from cycle 2; with q_rs1=7, rs1_busy=1. ALU write to 7 granted in cycle 4 -> we3 in cycle 5, sb_busy[7]=0 from cycle 6. A new iss_rd=7 in cycle 5 keeps sb_busy[7]=1.
- Bypass: with RF_WB_BYPASS_EN and q_rs2=7 in cycle 5 -> byp2_hit=1, byp2_data=wd3, rs2_busy=0. Without the macro -> rs2_busy=1 in cycle 5.
- Reset mid-operation: rst_n low while a grant is pending and sb_busy=0x80 -> we3=0 immediately, sb_busy=0, readys 0; after release the first request is granted normally.
